sa_result_collector: RTL and testbench
======================================

// Module: sa_result_collector
// PURPOSE
//  Downstream stage of the 3x3 systolic NPU array. Takes the column-skewed partial-sum
//  outputs (column j lags column 0 by j cycles) and deskews them into whole result rows.
//  Writes each aligned row into a small result buffer. The Wishbone read path fetches
//  rows from this buffer by address. Tracks row count and completion, and raises
//  sticky error flags for skew mismatch and overflow.
// PARAMETERS
//  N     3   number of array columns (outputs per row)
//  OW    16  width of one column partial sum, bits
//  ROWS  4   result buffer depth, in rows
//  AW    2   row address width; must satisfy 2**AW >= ROWS
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, synchronous, active-high
//  start      in   1       1-cycle pulse: flush, clear count/flags, arm collection
//  col_valid  in   N       per-column valid from the array; bit j qualifies column j
//  col_data   in   N*OW    column j partial sum on bits [j*OW +: OW]
//  rd_en      in   1       read request
//  rd_addr    in   AW      row to read
//  rd_data    out  N*OW    registered read data, same packing as col_data
//  rd_valid   out  1       1 cycle after rd_en; high only if the row was written
//  row_count  out  AW+1    rows written since last start (0..ROWS)
//  busy       out  1       high in COLLECT
//  done       out  1       high in DONE (ROWS rows written)
//  skew_err   out  1       sticky: deskewed valids disagreed on some cycle
//  overflow   out  1       sticky: an aligned row arrived while in DONE
// BEHAVIOUR
//  - Reset:
//    - state=IDLE; rd_data, rd_valid, row_count, busy, done, skew_err and overflow all 0.
//    - Deskew registers cleared. Buffer contents are don't-care.
//  - Deskew:
//    - Column j data and valid pass through (N-1-j) register stages. Column N-1 has zero stages.
//    - Row-aligned valid av = AND of all deskewed valids.
//    - mis = OR of deskewed valids AND NOT av.
//  - States:
//    - IDLE: deskew pipeline holds zeros; col_valid is ignored and never captured.
//    - COLLECT (entered on start):
//      - If av, write the aligned row to buf[row_count] and increment row_count.
//      - If mis, set skew_err and drop the row.
//      - When the write brings row_count to ROWS, go to DONE on the next edge.
//    - DONE: any av sets overflow. The row is dropped and row_count holds.
//  - start has priority in every state. On start:
//    - Deskew pipeline zeroed; col_valid is not captured that cycle.
//    - row_count, skew_err and overflow cleared; state goes to COLLECT.
//    - Buffer contents are not cleared.
//  - Latency: column 0 sample at cycle t appears as row data at cycle t+N-1.
//    It is written to the buffer at the edge ending that cycle.
//  - Read: rd_en at cycle t gives rd_data/rd_valid at t+1.
//    - rd_valid = rd_en && (rd_addr < row_count), using row_count at cycle t.
//    - rd_data = buf[rd_addr] when valid, else 0.
//    - Without rd_en: rd_valid=0 and rd_data holds its last value.
//  - Reading the row being written in the same cycle reports invalid, since its
//    address equals row_count.
//  - rst mid-operation: returns to IDLE immediately; any partial row in flight is lost.
//  - Data is stored unmodified. No sign handling or saturation happens in this block.
// TESTING (N=3, OW=16, ROWS=4)
//  1. Reset, then read addr 0 -> rd_valid=0, rd_data=0, busy=0, done=0.
//  2. start; feed 4 properly skewed rows, row r columns = {r*3+3, r*3+2, r*3+1}.
//     -> row_count steps 1..4, then done=1.
//     -> reading addr 2 gives rd_data={16'd9, 16'd8, 16'd7}, rd_valid=1.
//  3. start; drive col_valid=3'b111 unskewed on one cycle.
//     -> skew_err=1, row_count stays 0.
//  4. After done, feed a 5th skewed row -> overflow=1, row_count=4, buf[0..3] unchanged.
//  5. While col_valid is active in IDLE -> no writes, row_count=0.
//     start mid-row during COLLECT -> partial row discarded, row_count=0.
//  6. rst asserted mid-collection after 2 rows -> next cycle IDLE, all outputs 0.
//     Then start plus 1 row -> row_count=1.

Source files
------------

// File: rtl/sa_result_collector.sv
// Result collector for the systolic array: deskews column outputs into whole rows,
// buffers them for addressed reads, and tracks row count, completion and error flags.
module sa_result_collector #(
  parameter int N    = 3,
  parameter int OW   = 16,
  parameter int ROWS = 4,
  parameter int AW   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [N-1:0]      i_col_valid,
  input  logic [N*OW-1:0]   i_col_data,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [N*OW-1:0]   o_rd_data,
  output logic              o_rd_valid,
  output logic [AW:0]       o_row_count,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_skew_err,
  output logic              o_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_flush;
  logic              w_av;
  logic              w_mis;
  logic              w_wr;
  logic              w_err_set;
  logic              w_ovf_set;
  logic              w_rd_hit;
  logic [N-1:0]      w_dv;
  logic [N*OW-1:0]   w_row;
  logic [N*OW-1:0]   r_buf [ROWS];
  logic [AW:0]       r_row_count;
  logic              r_busy;
  logic              r_done;
  logic              r_skew_err;
  logic              r_overflow;
  logic              r_rd_valid;
  logic [N*OW-1:0]   r_rd_data;

  // Pipeline is held empty in IDLE and wiped on start, so nothing is captured then.
  assign w_flush = (r_state == ST_IDLE) || i_start;

  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int D = N - 1 - j;
    logic w_in_v;
    assign w_in_v = i_col_valid[j] & ~w_flush;

    if (D == 0) begin : g_pass
      assign w_dv[j]            = w_in_v;
      assign w_row[j*OW +: OW]  = i_col_data[j*OW +: OW];
    end else begin : g_dly
      logic [D-1:0]  r_v;
      logic [OW-1:0] r_d [D];

      // Deskew delay line for this column.
      always_ff @(posedge clk) begin
        if (rst || w_flush) begin
          r_v <= '0;
          for (int k = 0; k < D; k++) r_d[k] <= '0;
        end else begin
          r_v[0] <= w_in_v;
          r_d[0] <= i_col_data[j*OW +: OW];
          for (int k = 1; k < D; k++) begin
            r_v[k] <= r_v[k-1];
            r_d[k] <= r_d[k-1];
          end
        end
      end

      assign w_dv[j]           = r_v[D-1];
      assign w_row[j*OW +: OW] = r_d[D-1];
    end
  end

  assign w_av     = &w_dv;
  assign w_mis    = (|w_dv) & ~w_av;
  assign w_rd_hit = i_rd_en && ({1'b0, i_rd_addr} < r_row_count);

  // Next-state and per-cycle actions; start overrides everything.
  always_comb begin
    w_next    = r_state;
    w_wr      = 1'b0;
    w_err_set = 1'b0;
    w_ovf_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next = ST_IDLE;
      end
      ST_COLLECT: begin
        w_err_set = w_mis;
        if (w_av) begin
          w_wr = 1'b1;
          if (r_row_count == (AW+1)'(ROWS - 1)) begin
            w_next = ST_DONE;
          end else begin
            w_next = ST_COLLECT;
          end
        end else begin
          w_next = ST_COLLECT;
        end
      end
      ST_DONE: begin
        w_ovf_set = w_av;
        w_next    = ST_DONE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    if (i_start) begin
      w_next    = ST_COLLECT;
      w_wr      = 1'b0;
      w_err_set = 1'b0;
      w_ovf_set = 1'b0;
    end else begin
      w_next = w_next;
    end
  end

  // State, row counter, status and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_row_count <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_skew_err  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == ST_COLLECT);
      r_done  <= (w_next == ST_DONE);
      if (i_start) begin
        r_row_count <= '0;
        r_skew_err  <= 1'b0;
        r_overflow  <= 1'b0;
      end else begin
        if (w_wr) r_row_count <= r_row_count + (AW+1)'(1);
        r_skew_err <= r_skew_err | w_err_set;
        r_overflow <= r_overflow | w_ovf_set;
      end
    end
  end

  // Result buffer storage; contents survive start and reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_buf[r_row_count[AW-1:0]] <= w_row;
  end

  // Registered read port; data holds when no read is requested.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (i_rd_en) begin
      r_rd_valid <= w_rd_hit;
      r_rd_data  <= w_rd_hit ? r_buf[i_rd_addr] : '0;
    end else begin
      r_rd_valid <= 1'b0;
    end
  end

  assign o_rd_data   = r_rd_data;
  assign o_rd_valid  = r_rd_valid;
  assign o_row_count = r_row_count;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_skew_err  = r_skew_err;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_sa_result_collector.sv
// Scoreboard bench for sa_result_collector: directed skewed-row feeds, status checks,
// and read responses checked by an independent monitor against queued expectations.
module tb_sa_result_collector;
  localparam int N = 3;
  localparam int OW = 16;
  localparam int ROWS = 4;
  localparam int AW = 2;

  logic            clk;
  logic            rst;
  logic            i_start;
  logic [N-1:0]    i_col_valid;
  logic [N*OW-1:0] i_col_data;
  logic            i_rd_en;
  logic [AW-1:0]   i_rd_addr;
  logic [N*OW-1:0] o_rd_data;
  logic            o_rd_valid;
  logic [AW:0]     o_row_count;
  logic            o_busy;
  logic            o_done;
  logic            o_skew_err;
  logic            o_overflow;

  int n_cmp = 0;
  int n_bad = 0;
  logic [N*OW:0] sb [$];

  sa_result_collector #(.N(N), .OW(OW), .ROWS(ROWS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_col_valid(i_col_valid),
    .i_col_data(i_col_data), .i_rd_en(i_rd_en), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_row_count(o_row_count),
    .o_busy(o_busy), .o_done(o_done), .o_skew_err(o_skew_err), .o_overflow(o_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Row r carries {3r+3, 3r+2, 3r+1} on columns {2,1,0}.
  function automatic logic [N*OW-1:0] rowv(input int r);
    return {16'(r*3+3), 16'(r*3+2), 16'(r*3+1)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive cycle c of a skewed feed of n rows starting at row index first.
  task automatic drive_cycle(input int first, input int n, input int c);
    logic [N-1:0]    v;
    logic [N*OW-1:0] d;
    logic [N*OW-1:0] rv;
    v = '0;
    d = '0;
    for (int j = 0; j < N; j++) begin
      int r;
      r = c - j;
      if (r >= 0 && r < n) begin
        rv = rowv(first + r);
        v[j] = 1'b1;
        d[j*OW +: OW] = rv[j*OW +: OW];
      end
    end
    i_col_valid = v;
    i_col_data  = d;
  endtask

  task automatic idle();
    i_col_valid = '0;
    i_col_data  = '0;
    @(negedge clk);
  endtask

  task automatic feed(input int first, input int n);
    for (int c = 0; c < n + N - 1; c++) begin
      drive_cycle(first, n, c);
      @(negedge clk);
    end
    idle();
  endtask

  task automatic do_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic v, input logic [N*OW-1:0] d);
    sb.push_back({v, d});
    i_rd_en   = 1'b1;
    i_rd_addr = a;
    @(negedge clk);
    i_rd_en   = 1'b0;
  endtask

  // Monitor: every read request gets its response compared one cycle later.
  initial begin
    logic [N*OW:0] e;
    forever begin
      @(posedge clk);
      if (i_rd_en === 1'b1) begin
        #1;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL read_unexpected: got v=%0b d=%h with no expectation queued", o_rd_valid, o_rd_data);
        end else begin
          e = sb.pop_front();
          if ({o_rd_valid, o_rd_data} !== e) begin
            n_bad++;
            $display("FAIL read: got v=%0b d=%h expected v=%0b d=%h",
                     o_rd_valid, o_rd_data, e[N*OW], e[N*OW-1:0]);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; i_start = 1'b0; i_col_valid = '0; i_col_data = '0;
    i_rd_en = 1'b0; i_rd_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_count", o_row_count, 0);
    chk("rst_rdv", o_rd_valid, 0);
    chk("rst_rdd", o_rd_data, 0);
    chk("rst_skew", o_skew_err, 0);
    chk("rst_ovf", o_overflow, 0);
    rd(2'd0, 1'b0, '0);

    // Valid columns in IDLE are ignored
    feed(0, 2);
    chk("idle_count", o_row_count, 0);
    chk("idle_busy", o_busy, 0);
    rd(2'd0, 1'b0, '0);

    // Four skewed rows; row being written reads back invalid
    do_start();
    chk("start_busy", o_busy, 1);
    for (int c = 0; c < 6; c++) begin
      drive_cycle(0, 4, c);
      if (c == 2) begin
        sb.push_back({1'b0, 48'h0});
        i_rd_en = 1'b1;
        i_rd_addr = 2'd0;
      end
      @(negedge clk);
      i_rd_en = 1'b0;
      chk($sformatf("count_c%0d", c), o_row_count, (c >= 2) ? c - 1 : 0);
    end
    idle();
    chk("full_done", o_done, 1);
    chk("full_busy", o_busy, 0);
    rd(2'd2, 1'b1, 48'h0009_0008_0007);
    rd(2'd3, 1'b1, rowv(3));

    // Fifth row after done overflows and is dropped
    feed(4, 1);
    chk("ovf_flag", o_overflow, 1);
    chk("ovf_count", o_row_count, 4);
    chk("ovf_done", o_done, 1);
    for (int a = 0; a < 4; a++) rd(2'(a), 1'b1, rowv(a));

    // Unskewed valids raise skew_err and write nothing
    do_start();
    chk("st_ovf_clr", o_overflow, 0);
    chk("st_done_clr", o_done, 0);
    i_col_valid = 3'b111;
    i_col_data  = 48'h1111_2222_3333;
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    chk("skew_flag", o_skew_err, 1);
    chk("skew_count", o_row_count, 0);
    rd(2'd0, 1'b0, '0);

    // start in the middle of a row discards it
    do_start();
    chk("st_skew_clr", o_skew_err, 0);
    drive_cycle(5, 1, 0);
    @(negedge clk);
    drive_cycle(5, 1, 1);
    @(negedge clk);
    drive_cycle(5, 1, 2);
    do_start();
    idle();
    repeat (3) @(negedge clk);
    chk("midrow_count", o_row_count, 0);
    chk("midrow_skew", o_skew_err, 0);

    // Reset mid-collection after two rows
    do_start();
    for (int c = 0; c < 4; c++) begin
      drive_cycle(10, 3, c);
      if (c == 3) begin
        sb.push_back({1'b1, rowv(10)});
        i_rd_en = 1'b1;
        i_rd_addr = 2'd0;
      end
      @(negedge clk);
      i_rd_en = 1'b0;
    end
    chk("pre_rst_count", o_row_count, 2);
    drive_cycle(10, 3, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle();
    chk("mrst_busy", o_busy, 0);
    chk("mrst_count", o_row_count, 0);
    chk("mrst_rdd", o_rd_data, 0);
    chk("mrst_rdv", o_rd_valid, 0);
    do_start();
    feed(20, 1);
    chk("after_rst_count", o_row_count, 1);
    rd(2'd0, 1'b1, rowv(20));
    rd(2'd1, 1'b0, '0);

    repeat (3) @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
